// File: rtl/serial_alu_seq.sv
// Bit-serial ADD/SUB/AND/XOR sequencer driving an external 3-bit bit counter.
// Optional signed-overflow output enabled by defining SERIAL_ALU_OVF_EN.
module serial_alu_seq (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cnt_done,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       busy,
    output logic       valid,
    output logic [7:0] result,
    output logic       carry,
`ifdef SERIAL_ALU_OVF_EN
    output logic       ovf,
`endif
    output logic       zero
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [7:0] sa;
    logic [7:0] sb;
    logic [1:0] opr;
    logic       c;
    logic       c_n;
    logic       zacc;
    logic       bb;
    logic       r;
    logic       arith;
    logic       accept;

    assign accept = (state == IDLE) && start;
    assign arith  = ~opr[1];

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    // Next state and counter/handshake decode
    always_comb begin
        state_n = state;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        valid   = 1'b0;
        busy    = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (start) begin
                    cnt_clr = rstn;
                    state_n = RUN;
                end
            end
            RUN: begin
                cnt_en = 1'b1;
                if (cnt_done) state_n = DONE;
            end
            DONE: begin
                valid   = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // One-bit ALU slice; SUB adds the inverted operand with carry-in 1
    always_comb begin
        bb  = sb[0] ^ (opr == OP_SUB);
        r   = 1'b0;
        c_n = c;
        unique case (opr)
            OP_ADD, OP_SUB: begin
                r   = sa[0] ^ bb ^ c;
                c_n = (sa[0] & bb) | (sa[0] & c) | (bb & c);
            end
            OP_AND:  r = sa[0] & sb[0];
            OP_XOR:  r = sa[0] ^ sb[0];
            default: r = 1'b0;
        endcase
    end

    // Operand shift registers, result accumulation and flag capture
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sa     <= '0;
            sb     <= '0;
            opr    <= OP_ADD;
            c      <= 1'b0;
            zacc   <= 1'b0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
            ovf    <= 1'b0;
`endif
        end else if (accept) begin
            sa     <= a;
            sb     <= b;
            opr    <= op;
            c      <= (op == OP_SUB);
            zacc   <= 1'b0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
            ovf    <= 1'b0;
`endif
        end else if (state == RUN) begin
            result <= {r, result[7:1]};
            sa     <= sa >> 1;
            sb     <= sb >> 1;
            zacc   <= zacc | r;
            c      <= c_n;
            if (cnt_done) begin
                carry <= arith & c_n;
                zero  <= ~(zacc | r);
`ifdef SERIAL_ALU_OVF_EN
                ovf   <= arith & (c ^ c_n);
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_alu_seq.sv
// Self-checking bench for serial_alu_seq with a behavioural bit counter.
// Table vectors, random ops against an arithmetic model, start-hold and reset cases.
`timescale 1ns/1ps
module tb_serial_alu_seq;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       cnt_done;
    logic       cnt_en;
    logic       cnt_clr;
    logic       busy;
    logic       valid;
    logic [7:0] result;
    logic       carry;
    logic       zero;
    logic       ovf;

    int total = 0;
    int bad = 0;

    serial_alu_seq dut (
        .clk(clk),
        .rstn(rstn),
        .start(start),
        .op(op),
        .a(a),
        .b(b),
        .cnt_done(cnt_done),
        .cnt_en(cnt_en),
        .cnt_clr(cnt_clr),
        .busy(busy),
        .valid(valid),
        .result(result),
        .carry(carry),
`ifdef SERIAL_ALU_OVF_EN
        .ovf(ovf),
`endif
        .zero(zero)
    );

`ifndef SERIAL_ALU_OVF_EN
    assign ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    // External 3-bit bit counter
    logic [2:0] cnt = 3'd0;
    always @(posedge clk) begin
        if (cnt_clr)     cnt <= 3'd0;
        else if (cnt_en) cnt <= cnt + 3'd1;
    end
    assign cnt_done = (cnt == 3'd7);

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic       c;
        logic       z;
        logic       o;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: {ovf, zero, carry, result} from plain arithmetic
    function automatic logic [10:0] model(input logic [1:0] mop,
                                          input logic [7:0] ma,
                                          input logic [7:0] mb);
        int s;
        logic [7:0] rr;
        logic cc, oo;
        cc = 1'b0;
        oo = 1'b0;
        case (mop)
            2'd0: begin
                s  = int'(ma) + int'(mb);
                rr = s[7:0];
                cc = (s > 255);
                oo = (ma[7] == mb[7]) && (rr[7] != ma[7]);
            end
            2'd1: begin
                s  = int'(ma) - int'(mb);
                rr = s[7:0];
                cc = (ma >= mb);
                oo = (ma[7] != mb[7]) && (rr[7] != ma[7]);
            end
            2'd2: rr = ma & mb;
            default: rr = ma ^ mb;
        endcase
        return {oo, (rr == 8'h00), cc, rr};
    endfunction

    task automatic do_op(input logic [1:0] top, input logic [7:0] ta,
                         input logic [7:0] tb_, input logic [7:0] er,
                         input logic ec, input logic ez, input logic eo);
        int lat;
        int en_n;
        int clr_n;
        int busy_n;
        bit got;
        @(negedge clk);
        start = 1'b1;
        op = top;
        a = ta;
        b = tb_;
        #1;
        chk("clr_at_T", cnt_clr, 1);
        chk("idle_at_T", busy, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        op = 2'($urandom);
        lat = 0;
        en_n = 0;
        clr_n = 0;
        busy_n = 0;
        got = 1'b0;
        for (int i = 1; i <= 20 && !got; i++) begin
            if (cnt_en) en_n++;
            if (cnt_clr) clr_n++;
            if (busy) busy_n++;
            if (valid) begin
                got = 1'b1;
                lat = i;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        chk("valid_seen", got, 1);
        chk("latency", lat, 9);
        chk("cnt_en_cycles", en_n, 8);
        chk("cnt_clr_extra", clr_n, 0);
        chk("busy_cycles", busy_n, 9);
        chk("result", result, er);
        chk("carry", carry, ec);
        chk("zero", zero, ez);
`ifdef SERIAL_ALU_OVF_EN
        chk("ovf", ovf, eo);
`else
        if (eo === 1'bx) chk("ovf_x", eo, 0);
`endif
        @(posedge clk);
        #1;
        chk("valid_pulse_end", valid, 0);
        chk("idle_after", busy, 0);
        chk("result_hold", result, er);
    endtask

    vec_t tv[7];
    logic [1:0] hop[20];
    logic [7:0] ha[20];
    logic [7:0] hb[20];

    initial begin
        logic [10:0] m;
        int nv;

        tv[0] = '{2'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
        tv[1] = '{2'd1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0};
        tv[2] = '{2'd1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0};
        tv[3] = '{2'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
        tv[4] = '{2'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
        tv[5] = '{2'd3, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b0};
        tv[6] = '{2'd1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1};

        #2;
        rstn = 1'b0;
        start = 1'b1;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_result", result, 0);
        chk("rst_carry", carry, 0);
        chk("rst_zero", zero, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_cnt_clr", cnt_clr, 0);
        chk("rst_cnt_en", cnt_en, 0);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        foreach (tv[i])
            do_op(tv[i].op, tv[i].a, tv[i].b, tv[i].r, tv[i].c, tv[i].z,
                  tv[i].o);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] rop;
            logic [7:0] ra;
            logic [7:0] rb;
            rop = 2'($urandom);
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (i % 8 == 0) rb = ra;
            m = model(rop, ra, rb);
            do_op(rop, ra, rb, m[7:0], m[8], m[9], m[10]);
        end

        for (int k = 0; k < 20; k++) begin
            hop[k] = 2'($urandom);
            ha[k] = 8'($urandom);
            hb[k] = 8'($urandom);
        end
        nv = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            start = 1'b1;
            op = hop[k];
            a = ha[k];
            b = hb[k];
            @(posedge clk);
            #1;
            if (valid) nv++;
            if (k + 1 == 9) begin
                m = model(hop[0], ha[0], hb[0]);
                chk("hold_valid_1", valid, 1);
                chk("hold_result_1", result, m[7:0]);
                chk("hold_carry_1", carry, m[8]);
            end
            if (k + 1 == 10) begin
                chk("hold_idle_10", busy, 0);
                chk("hold_clr_10", cnt_clr, 1);
            end
            if (k + 1 == 19) begin
                m = model(hop[10], ha[10], hb[10]);
                chk("hold_valid_2", valid, 1);
                chk("hold_result_2", result, m[7:0]);
                chk("hold_zero_2", zero, m[9]);
            end
        end
        start = 1'b0;
        chk("hold_valid_count", nv, 2);
        @(posedge clk);
        #1;

        @(negedge clk);
        start = 1'b1;
        op = 2'd0;
        a = 8'h5A;
        b = 8'h11;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("pre_rst_busy", busy, 1);
        rstn = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_result", result, 0);
        chk("abort_cnt_en", cnt_en, 0);
        nv = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (valid) nv++;
        end
        chk("abort_no_valid", nv, 0);
        @(negedge clk);
        rstn = 1'b1;
        do_op(2'd0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d",
                 total, bad);
        $fatal(1, "timeout");
    end

endmodule
